universal_shift_reg_nbit: RTL and testbench

Parametrised N-bit register that replaces the plain PIPO register wherever data must be shifted or rotated as well as loaded. It supports parallel load and multi-step shift/rotate operations (logical, arithmetic, rotate) driven by a start/amount command. A small FSM runs each command for a counted number of cycles and reports busy/done. It sits in the datapath register slot, with the same clock and reset as the PIPO it supersedes.

---
 rtl/usr_pkg.sv | 27 ++
 rtl/usr_step.sv | 44 ++++
 rtl/universal_shift_reg_nbit.sv | 119 +++++++++++
 tb/tb_universal_shift_reg_nbit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register.
// Mode codes, FSM states and a mode classifier.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic is_shift(
    input logic [2:0] m
  );
    return m inside {MODE_SHL, MODE_SHR,
                     MODE_ROL, MODE_ROR,
                     MODE_ASR};
  endfunction

endpackage

// File: rtl/usr_step.sv
// One shift/rotate step of an N-bit word.
// Pure combinational; non-shift modes pass q through.
module usr_step
  import usr_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] q,
  input  logic [2:0]   mode,
  input  logic         fill,
  output logic [N-1:0] q_nxt,
  output logic         out_bit
);

  // select the single-step result for the mode
  always_comb begin
    q_nxt   = q;
    out_bit = 1'b0;
    case (mode)
      MODE_SHL: begin
        q_nxt   = {q[N-2:0], fill};
        out_bit = q[N-1];
      end
      MODE_SHR: begin
        q_nxt   = {fill, q[N-1:1]};
        out_bit = q[0];
      end
      MODE_ROL: begin
        q_nxt   = {q[N-2:0], q[N-1]};
        out_bit = q[N-1];
      end
      MODE_ROR: begin
        q_nxt   = {q[0], q[N-1:1]};
        out_bit = q[0];
      end
      MODE_ASR: begin
        q_nxt   = {q[N-1], q[N-1:1]};
        out_bit = q[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg_nbit.sv
// N-bit register with load and multi-step shift/rotate.
// The counter holds the steps still to run after the first.
module universal_shift_reg_nbit
  import usr_pkg::*;
#(
  parameter  int N  = 16,
  localparam int AW = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          reset_al_in,
  input  logic          start_in,
  input  logic [2:0]    mode_in,
  input  logic [AW-1:0] amount_in,
  input  logic          ser_in,
  input  logic [N-1:0]  d_in,
  output logic [N-1:0]  q_out,
  output logic          ser_out,
  output logic          busy_out,
  output logic          done_out
);

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [2:0]    mode_r, mode_nxt;
  logic          fill_r, fill_nxt;
  logic [N-1:0]  q_r, q_nxt;
  logic          ser_r, ser_nxt;
  logic          done_r, done_nxt;

  logic          idle;
  logic [2:0]    step_mode;
  logic          step_fill;
  logic [N-1:0]  step_q;
  logic          step_out;

  assign idle      = (state == ST_IDLE);
  assign step_mode = idle ? mode_in : mode_r;
  assign step_fill = idle ? ser_in  : fill_r;

  usr_step #(.N(N)) u_step (
    .q       (q_r),
    .mode    (step_mode),
    .fill    (step_fill),
    .q_nxt   (step_q),
    .out_bit (step_out)
  );

  // next-state, datapath and done decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode_r;
    fill_nxt  = fill_r;
    q_nxt     = q_r;
    ser_nxt   = ser_r;
    done_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_in) begin
          if (mode_in == MODE_LOAD) begin
            q_nxt    = d_in;
            done_nxt = 1'b1;
          end else if (is_shift(mode_in)) begin
            if (amount_in == '0) begin
              done_nxt = 1'b1;
            end else begin
              q_nxt    = step_q;
              ser_nxt  = step_out;
              mode_nxt = mode_in;
              fill_nxt = ser_in;
              cnt_nxt  = amount_in - 1'b1;
              if (amount_in == AW'(1))
                done_nxt  = 1'b1;
              else
                state_nxt = ST_SHIFT;
            end
          end
        end
      end
      ST_SHIFT: begin
        q_nxt   = step_q;
        ser_nxt = step_out;
        cnt_nxt = cnt - 1'b1;
        if (cnt == AW'(1)) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mode_r <= MODE_HOLD;
      fill_r <= 1'b0;
      q_r    <= '0;
      ser_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mode_r <= mode_nxt;
      fill_r <= fill_nxt;
      q_r    <= q_nxt;
      ser_r  <= ser_nxt;
      done_r <= done_nxt;
    end
  end

  assign q_out    = q_r;
  assign ser_out  = ser_r;
  assign busy_out = (state == ST_SHIFT);
  assign done_out = done_r;

endmodule

// File: tb/tb_universal_shift_reg_nbit.sv
// Bench for universal_shift_reg_nbit.
// Closed-form model compared every cycle plus directed literals.
module tb_universal_shift_reg_nbit;
  import usr_pkg::*;

  localparam int N  = 16;
  localparam int AW = $clog2(N+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start_in = 1'b0;
  logic [2:0]    mode_in = MODE_HOLD;
  logic [AW-1:0] amount_in = '0;
  logic          ser_in = 1'b0;
  logic [N-1:0]  d_in = '0;
  logic [N-1:0]  q_out;
  logic          ser_out;
  logic          busy_out;
  logic          done_out;

  int n_pass  = 0;
  int n_total = 0;

  universal_shift_reg_nbit #(.N(N)) dut (
    .clk         (clk),
    .reset_al_in (rst_n),
    .start_in    (start_in),
    .mode_in     (mode_in),
    .amount_in   (amount_in),
    .ser_in      (ser_in),
    .d_in        (d_in),
    .q_out       (q_out),
    .ser_out     (ser_out),
    .busy_out    (busy_out),
    .done_out    (done_out)
  );

  always #5 clk = ~clk;

  task automatic check(string name,
                       logic [31:0] act,
                       logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  // word after i steps of mode m from base b
  function automatic logic [N-1:0] after(
    logic [2:0] m, logic [N-1:0] b,
    logic f, int i);
    logic [N-1:0]        ones;
    logic signed [N-1:0] s;
    logic [2*N-1:0]      w;
    int                  r;
    ones = '1;
    s    = b;
    r    = i % N;
    case (m)
      MODE_SHL:
        if (i >= N) return {N{f}};
        else return (b << i) | (f ? ~(ones << i) : '0);
      MODE_SHR:
        if (i >= N) return {N{f}};
        else return (b >> i) | (f ? ~(ones >> i) : '0);
      MODE_ROL: begin
        w = {b, b} << r;
        return w[2*N-1:N];
      end
      MODE_ROR: begin
        w = {b, b} >> r;
        return w[N-1:0];
      end
      MODE_ASR: return s >>> i;
      default:  return b;
    endcase
  endfunction

  // bit leaving the word on step i (i >= 1)
  function automatic logic out_at(
    logic [2:0] m, logic [N-1:0] b,
    logic f, int i);
    logic [N-1:0] p;
    p = after(m, b, f, i - 1);
    if (m == MODE_SHL || m == MODE_ROL)
      return p[N-1];
    return p[0];
  endfunction

  logic [N-1:0] m_q, m_base;
  logic         m_ser, m_done, m_act, m_fill;
  logic [2:0]   m_mode;
  int           m_i, m_k;

  // reference model: result from base word and step index
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0; m_ser <= 1'b0; m_done <= 1'b0;
      m_act <= 1'b0; m_i <= 0; m_k <= 0;
      m_base <= '0; m_mode <= MODE_HOLD;
      m_fill <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_act) begin
        m_i   <= m_i + 1;
        m_q   <= after(m_mode, m_base, m_fill, m_i + 1);
        m_ser <= out_at(m_mode, m_base, m_fill, m_i + 1);
        if (m_i + 1 == m_k) begin
          m_act  <= 1'b0;
          m_done <= 1'b1;
        end
      end else if (start_in) begin
        if (mode_in == MODE_LOAD) begin
          m_q    <= d_in;
          m_done <= 1'b1;
        end else if (mode_in inside {MODE_SHL, MODE_SHR,
                     MODE_ROL, MODE_ROR, MODE_ASR}) begin
          if (amount_in == 0) begin
            m_done <= 1'b1;
          end else begin
            m_base <= m_q;
            m_mode <= mode_in;
            m_fill <= ser_in;
            m_k    <= int'(amount_in);
            m_i    <= 1;
            m_q    <= after(mode_in, m_q, ser_in, 1);
            m_ser  <= out_at(mode_in, m_q, ser_in, 1);
            if (amount_in == 1) m_done <= 1'b1;
            else m_act <= 1'b1;
          end
        end
      end
    end
  end

  // compare DUT to model away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("model_q",    32'(q_out),    32'(m_q));
      check("model_ser",  32'(ser_out),  32'(m_ser));
      check("model_busy", 32'(busy_out), 32'(m_act));
      check("model_done", 32'(done_out), 32'(m_done));
    end
  end

  task automatic issue(logic [2:0] m, int amt,
                       logic f, logic [N-1:0] d);
    start_in  = 1'b1;
    mode_in   = m;
    amount_in = AW'(amt);
    ser_in    = f;
    d_in      = d;
    @(negedge clk);
    start_in  = 1'b0;
    mode_in   = MODE_HOLD;
    amount_in = '0;
    ser_in    = 1'b0;
  endtask

  task automatic wait_done(input int bc0,
                           output int bc);
    bit ok;
    ok = 1'b0;
    bc = bc0;
    for (int i = 0; i < 100; i++) begin
      if (done_out) begin
        ok = 1'b1;
        break;
      end
      if (busy_out) bc++;
      @(negedge clk);
    end
    if (!ok) check("wait_done_timeout", 0, 1);
  endtask

  int bc, bc0;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_q",    32'(q_out),    0);
    check("rst_ser",  32'(ser_out),  0);
    check("rst_busy", 32'(busy_out), 0);
    check("rst_done", 32'(done_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(MODE_LOAD, 0, 0, 16'hA5C3);
    check("load_q",    32'(q_out),    32'hA5C3);
    check("load_done", 32'(done_out), 1);
    check("load_busy", 32'(busy_out), 0);
    @(negedge clk);
    check("load_done_off", 32'(done_out), 0);

    issue(MODE_HOLD, 5, 1, 16'h0000);
    check("hold_done", 32'(done_out), 0);
    check("hold_q",    32'(q_out),    32'hA5C3);
    issue(MODE_RSVD, 3, 1, 16'h0000);
    check("rsvd_done", 32'(done_out), 0);
    check("rsvd_q",    32'(q_out),    32'hA5C3);

    issue(MODE_ROL, 4, 0, 16'h0000);
    bc0 = busy_out ? 1 : 0;
    start_in = 1'b1;
    mode_in  = MODE_LOAD;
    d_in     = 16'hFFFF;
    @(negedge clk);
    start_in = 1'b0;
    mode_in  = MODE_HOLD;
    wait_done(bc0, bc);
    check("rol_q",    32'(q_out),   32'h5C3A);
    check("rol_ser",  32'(ser_out), 0);
    check("rol_busy", bc,           3);
    @(negedge clk);
    check("rol_done_off", 32'(done_out), 0);

    issue(MODE_LOAD, 0, 0, 16'h8000);
    issue(MODE_ASR, 3, 0, 16'h0000);
    wait_done(0, bc);
    check("asr_q",    32'(q_out),   32'hF000);
    check("asr_ser",  32'(ser_out), 0);
    check("asr_busy", bc,           2);

    issue(MODE_LOAD, 0, 0, 16'h8000);
    issue(MODE_SHR, 3, 0, 16'h0000);
    wait_done(0, bc);
    check("shr_q",   32'(q_out),   32'h1000);
    check("shr_ser", 32'(ser_out), 0);

    issue(MODE_LOAD, 0, 0, 16'h0000);
    issue(MODE_SHL, 20, 1, 16'h0000);
    wait_done(0, bc);
    check("shl20_q",    32'(q_out),   32'hFFFF);
    check("shl20_ser",  32'(ser_out), 1);
    check("shl20_busy", bc,           19);

    issue(MODE_LOAD, 0, 0, 16'h1234);
    issue(MODE_SHR, 0, 1, 16'h0000);
    check("amt0_done", 32'(done_out), 1);
    check("amt0_q",    32'(q_out),    32'h1234);
    check("amt0_busy", 32'(busy_out), 0);
    issue(MODE_ROR, 4, 0, 16'h0000);
    wait_done(0, bc);
    check("b2b_q",    32'(q_out),   32'h4123);
    check("b2b_ser",  32'(ser_out), 0);
    check("b2b_busy", bc,           3);

    issue(MODE_LOAD, 0, 0, 16'h00FF);
    issue(MODE_ROR, 8, 1, 16'h0000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_q",    32'(q_out),    0);
    check("arst_ser",  32'(ser_out),  0);
    check("arst_busy", 32'(busy_out), 0);
    check("arst_done", 32'(done_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(MODE_LOAD, 0, 0, 16'hBEEF);
    check("post_rst_q",    32'(q_out),    32'hBEEF);
    check("post_rst_done", 32'(done_out), 1);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
